// File: rtl/buffer_readout_controller_pkg.sv
// Shared constants for the acquisition read-out path: FSM encodings,
// Tx byte width and the channel selector type.
package buffer_readout_controller_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_READ    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_SEND    = 2'd3;

   localparam int TX_DATA_W = 8;

   typedef enum logic {
      CH_SEL_1 = 1'b0,
      CH_SEL_2 = 1'b1
   } ch_sel_e;

endpackage

// File: rtl/buffer_readout_controller_circular_addr_counter.sv
// Circular RAM read-address counter: loadable, increments with a natural
// power-of-two wrap from 2**AW-1 back to 0.
module circular_addr_counter #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [AW-1:0] load_addr_i,
   input  logic          inc_i,
   output logic [AW-1:0] addr_o
);

   logic [AW-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (load_i)
         addr_d = load_addr_i;
      else if (inc_i)
         addr_d = addr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst_i)
         addr_q <= '0;
      else
         addr_q <= addr_d;
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/buffer_readout_controller.sv
// Reads the last N captured samples of one channel out of the circular
// acquisition RAM and hands them to the Tx arbiter one byte at a time.
module buffer_readout_controller
   import buffer_readout_controller_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 12,
   parameter int BITS_ADC       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rqst_ch1,
   input  logic                      rqst_ch2,
   input  logic                      acq_done,
   input  logic [RAM_ADDR_WIDTH-1:0] wr_ptr,
   input  logic [15:0]               num_samples,
   output logic                      acq_stop,
   output logic                      ram_rd_en,
   output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [BITS_ADC-1:0]       ram_ch1_data,
   input  logic [BITS_ADC-1:0]       ram_ch2_data,
   output logic [TX_DATA_W-1:0]      tx_data,
   output logic                      tx_rdy,
   output logic                      tx_eof,
   input  logic                      tx_ack,
   output logic                      busy
);

   localparam int AW = RAM_ADDR_WIDTH;
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [1:0]           state_q, state_d;
   logic                 pend_q, pend_d;
   ch_sel_e              ch_q, ch_d;
   logic [AW:0]          cnt_q, cnt_d;
   logic [TX_DATA_W-1:0] tx_data_q, tx_data_d;
   logic                 acq_stop_q, acq_stop_d;

   logic                 accept;
   logic                 addr_load;
   logic                 addr_inc;
   logic [AW:0]          n_clamped;
   logic [AW-1:0]        start_addr;
   logic [AW-1:0]        addr;
   logic [BITS_ADC-1:0]  sel_data;

   // Asking for more than the buffer holds returns the whole buffer, oldest first.
   assign n_clamped  = (num_samples >= 16'(DEPTH)) ? DEPTH : num_samples[AW:0];
   assign start_addr = wr_ptr - n_clamped[AW-1:0];
   assign sel_data   = (ch_q == CH_SEL_2) ? ram_ch2_data : ram_ch1_data;

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      ch_d       = ch_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      acq_stop_d = 1'b0;
      accept     = 1'b0;
      addr_load  = 1'b0;
      addr_inc   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            accept     = (rqst_ch1 || rqst_ch2) && !pend_q;
            acq_stop_d = accept;
            if (accept)
               ch_d = rqst_ch1 ? CH_SEL_1 : CH_SEL_2;
            // A fresh request may start in the same cycle it is accepted.
            if ((pend_q || accept) && acq_done) begin
               pend_d    = 1'b0;
               addr_load = 1'b1;
               cnt_d     = n_clamped;
               if (n_clamped != '0)
                  state_d = ST_READ;
            end else if (accept) begin
               pend_d = 1'b1;
            end
         end
         ST_READ: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            tx_data_d = TX_DATA_W'(sel_data);
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            if (tx_ack) begin
               cnt_d    = cnt_q - (AW+1)'(1);
               addr_inc = 1'b1;
               state_d  = (cnt_q == (AW+1)'(1)) ? ST_IDLE : ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pend_q     <= 1'b0;
         ch_q       <= CH_SEL_1;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         acq_stop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         ch_q       <= ch_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         acq_stop_q <= acq_stop_d;
      end
   end

   circular_addr_counter #(
      .AW (AW)
   ) u_addr (
      .clk         (clk),
      .rst_i       (rst),
      .load_i      (addr_load),
      .load_addr_i (start_addr),
      .inc_i       (addr_inc),
      .addr_o      (addr)
   );

   assign acq_stop    = acq_stop_q;
   assign ram_rd_en   = (state_q == ST_READ);
   assign ram_rd_addr = addr;
   assign tx_data     = tx_data_q;
   assign tx_rdy      = (state_q == ST_SEND);
   assign tx_eof      = (state_q == ST_SEND) && (cnt_q == (AW+1)'(1));
   assign busy        = pend_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_buffer_readout_controller.sv
// Directed bench for buffer_readout_controller with a 16-entry RAM (AW=4).
module tb_buffer_readout_controller;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rqst_ch1 = 1'b0;
   logic          rqst_ch2 = 1'b0;
   logic          acq_done = 1'b0;
   logic [AW-1:0] wr_ptr = '0;
   logic [15:0]   num_samples = '0;
   logic          acq_stop;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [7:0]    ram_ch1_data = '0;
   logic [7:0]    ram_ch2_data = '0;
   logic [7:0]    tx_data;
   logic          tx_rdy;
   logic          tx_eof;
   logic          tx_ack = 1'b0;
   logic          busy;

   int errors = 0;
   int checks = 0;

   int       n_rd, n_bytes;
   int       rd_addr [32];
   logic [7:0] bytes [32];
   logic     eofs [32];
   logic     timed_out;

   always #5 clk = ~clk;

   buffer_readout_controller #(
      .RAM_ADDR_WIDTH (AW),
      .BITS_ADC       (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rqst_ch1     (rqst_ch1),
      .rqst_ch2     (rqst_ch2),
      .acq_done     (acq_done),
      .wr_ptr       (wr_ptr),
      .num_samples  (num_samples),
      .acq_stop     (acq_stop),
      .ram_rd_en    (ram_rd_en),
      .ram_rd_addr  (ram_rd_addr),
      .ram_ch1_data (ram_ch1_data),
      .ram_ch2_data (ram_ch2_data),
      .tx_data      (tx_data),
      .tx_rdy       (tx_rdy),
      .tx_eof       (tx_eof),
      .tx_ack       (tx_ack),
      .busy         (busy)
   );

   // RAM model: ch1 holds 0x10+addr, ch2 holds 0xA0+addr, one-cycle read latency.
   always @(posedge clk) begin
      if (ram_rd_en) begin
         ram_ch1_data <= {4'h1, ram_rd_addr};
         ram_ch2_data <= {4'hA, ram_rd_addr};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Records reads and bytes, acking each byte at once, until busy falls.
   task automatic collect(input int max_cycles);
      n_rd = 0;
      n_bytes = 0;
      timed_out = 1'b1;
      for (int c = 0; c < max_cycles; c++) begin
         if (ram_rd_en && n_rd < 32) begin
            rd_addr[n_rd] = int'(ram_rd_addr);
            n_rd++;
         end
         if (tx_rdy && n_bytes < 32) begin
            bytes[n_bytes] = tx_data;
            eofs[n_bytes]  = tx_eof;
            n_bytes++;
            tx_ack = 1'b1;
         end
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
         tick();
         tx_ack = 1'b0;
      end
      tx_ack = 1'b0;
      $display("collect: %0d reads, %0d bytes, timeout=%0b", n_rd, n_bytes, timed_out);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({acq_stop, ram_rd_en, ram_rd_addr, tx_data, tx_rdy, tx_eof, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {acq_stop, ram_rd_en, ram_rd_addr, tx_data, tx_rdy, tx_eof, busy});
      end
   endtask

   task automatic test_basic_ch1();
      wr_ptr = 4'd10; num_samples = 16'd4; acq_done = 1'b1;
      rqst_ch1 = 1'b1;
      tick();
      rqst_ch1 = 1'b0;
      checks++;
      if (acq_stop !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_acq_stop: got stop=%b busy=%b required 1 1", acq_stop, busy);
      end
      checks++;
      if (ram_rd_en !== 1'b1 || ram_rd_addr !== 4'd6) begin
         errors++;
         $display("FAIL basic_first_read: got en=%b addr=%0d required 1 6", ram_rd_en, ram_rd_addr);
      end
      collect(100);
      checks++;
      if (timed_out || n_rd != 4 || n_bytes != 4) begin
         errors++;
         $display("FAIL basic_counts: got reads=%0d bytes=%0d timeout=%0b required 4 4 0",
                  n_rd, n_bytes, timed_out);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_addr[i] != 6 + i || bytes[i] !== 8'h16 + 8'(i) || eofs[i] !== (i == 3)) begin
            errors++;
            $display("FAIL basic_byte%0d: got addr=%0d data=%h eof=%b required %0d %h %b",
                     i, rd_addr[i], bytes[i], eofs[i], 6 + i, 8'h16 + 8'(i), i == 3);
         end
      end
   endtask

   task automatic test_wrap();
      int exp_a [5] = '{13, 14, 15, 0, 1};
      wr_ptr = 4'd2; num_samples = 16'd5; acq_done = 1'b1;
      rqst_ch1 = 1'b1;
      tick();
      rqst_ch1 = 1'b0;
      collect(100);
      checks++;
      if (timed_out || n_rd != 5 || n_bytes != 5) begin
         errors++;
         $display("FAIL wrap_counts: got reads=%0d bytes=%0d required 5 5", n_rd, n_bytes);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rd_addr[i] != exp_a[i] || bytes[i] !== 8'h10 + 8'(exp_a[i]) || eofs[i] !== (i == 4)) begin
            errors++;
            $display("FAIL wrap_byte%0d: got addr=%0d data=%h eof=%b required %0d %h %b",
                     i, rd_addr[i], bytes[i], eofs[i], exp_a[i], 8'h10 + 8'(exp_a[i]), i == 4);
         end
      end
   endtask

   task automatic test_priority();
      wr_ptr = 4'd4; num_samples = 16'd2; acq_done = 1'b1;
      rqst_ch1 = 1'b1; rqst_ch2 = 1'b1;
      tick();
      rqst_ch1 = 1'b0; rqst_ch2 = 1'b0;
      checks++;
      if (acq_stop !== 1'b1) begin
         errors++;
         $display("FAIL prio_acq_stop: got %b required 1", acq_stop);
      end
      collect(100);
      checks++;
      if (timed_out || n_bytes != 2 || bytes[0] !== 8'h12 || bytes[1] !== 8'h13) begin
         errors++;
         $display("FAIL prio_ch1_data: got n=%0d %h %h required 2 12 13", n_bytes, bytes[0], bytes[1]);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL prio_no_ch2: got busy=%b rd_en=%b required 0 0", busy, ram_rd_en);
      end
   endtask

   task automatic test_clamp();
      wr_ptr = 4'd7; num_samples = 16'd100; acq_done = 1'b1;
      rqst_ch2 = 1'b1;
      tick();
      rqst_ch2 = 1'b0;
      collect(200);
      checks++;
      if (timed_out || n_rd != 16 || n_bytes != 16) begin
         errors++;
         $display("FAIL clamp_counts: got reads=%0d bytes=%0d required 16 16", n_rd, n_bytes);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_addr[i] != (7 + i) % 16 || bytes[i] !== 8'hA0 + 8'((7 + i) % 16) || eofs[i] !== (i == 15)) begin
            errors++;
            $display("FAIL clamp_byte%0d: got addr=%0d data=%h eof=%b required %0d %h %b",
                     i, rd_addr[i], bytes[i], eofs[i], (7 + i) % 16, 8'hA0 + 8'((7 + i) % 16), i == 15);
         end
      end
   endtask

   task automatic test_pending();
      logic bad;
      wr_ptr = 4'd8; num_samples = 16'd2; acq_done = 1'b0;
      rqst_ch2 = 1'b1;
      tick();
      rqst_ch2 = 1'b0;
      checks++;
      if (acq_stop !== 1'b1 || busy !== 1'b1 || ram_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL pend_accept: got stop=%b busy=%b rd_en=%b required 1 1 0", acq_stop, busy, ram_rd_en);
      end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rqst_ch1 = (i == 0);
         tick();
         rqst_ch1 = 1'b0;
         if (ram_rd_en !== 1'b0 || acq_stop !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL pend_wait: got activity while waiting for acq_done required none");
      end
      acq_done = 1'b1;
      tick();
      checks++;
      if (ram_rd_en !== 1'b1 || ram_rd_addr !== 4'd6) begin
         errors++;
         $display("FAIL pend_start: got en=%b addr=%0d required 1 6", ram_rd_en, ram_rd_addr);
      end
      wr_ptr = 4'd0; num_samples = 16'd9; acq_done = 1'b0;
      collect(100);
      checks++;
      if (timed_out || n_bytes != 2 || bytes[0] !== 8'hA6 || bytes[1] !== 8'hA7
          || eofs[0] !== 1'b0 || eofs[1] !== 1'b1) begin
         errors++;
         $display("FAIL pend_ch2_data: got n=%0d %h/%b %h/%b required 2 a6/0 a7/1",
                  n_bytes, bytes[0], eofs[0], bytes[1], eofs[1]);
      end
   endtask

   task automatic test_zero();
      logic bad;
      wr_ptr = 4'd5; num_samples = 16'd0; acq_done = 1'b1;
      rqst_ch1 = 1'b1;
      tick();
      rqst_ch1 = 1'b0;
      checks++;
      if (acq_stop !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_accept: got stop=%b busy=%b required 1 0", acq_stop, busy);
      end
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ram_rd_en !== 1'b0 || tx_rdy !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL zero_idle: got read or byte activity required none");
      end
   endtask

   task automatic test_backpressure_and_abort();
      logic bad;
      int   waited;
      wr_ptr = 4'd3; num_samples = 16'd3; acq_done = 1'b1;
      rqst_ch1 = 1'b1;
      tick();
      rqst_ch1 = 1'b0;
      waited = 0;
      while (tx_rdy !== 1'b1 && waited < 10) begin
         tick();
         waited++;
      end
      checks++;
      if (tx_rdy !== 1'b1 || waited != 2 || tx_data !== 8'h10 || tx_eof !== 1'b0) begin
         errors++;
         $display("FAIL hold_first: got rdy=%b after %0d cycles data=%h eof=%b required 1 2 10 0",
                  tx_rdy, waited, tx_data, tx_eof);
      end
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_rdy !== 1'b1 || tx_data !== 8'h10 || tx_eof !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL hold_stable: got tx_rdy/tx_data changing without ack required stable");
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({acq_stop, ram_rd_en, ram_rd_addr, tx_data, tx_rdy, tx_eof, busy} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: got %b required all zero",
                  {acq_stop, ram_rd_en, ram_rd_addr, tx_data, tx_rdy, tx_eof, busy});
      end
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (tx_eof !== 1'b0 || tx_rdy !== 1'b0 || ram_rd_en !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_quiet: got activity after reset required none");
      end
   endtask

   initial begin
      test_reset();
      test_basic_ch1();
      test_wrap();
      test_priority();
      test_clamp();
      test_pending();
      test_zero();
      test_backpressure_and_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
